// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1, LSB first) fed by a small FIFO so producers can burst bytes.
// Define UART_TX_PARITY_EN to insert an even parity bit after D7 (11-bit frames).
`timescale 1ns/1ps

module uart_tx_fifo #(
  parameter int Baudrate = 24,
  parameter int DEPTH    = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [7:0]               Data_in,
  input  logic                     Valid,
  output logic                     Ready,
  output logic                     TX,
  output logic                     Busy,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (Baudrate > 1) ? $clog2(Baudrate) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(Baudrate - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [CW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      head;
  logic            push, pop, full, baud_last;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  // FIFO occupancy from pointer difference; the extra MSB distinguishes full from empty
  assign Count     = wr_ptr_q - rd_ptr_q;
  assign full      = (Count == CW'(DEPTH));
  assign Ready     = !full;
  assign push      = Valid && Ready;
  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign baud_last = (baud_q == BAUD_LAST);
  assign TX        = tx_q;
  assign Busy      = (state_q != IDLE) || (Count != '0);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (Count != '0) begin
          pop     = 1'b1;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baud_last) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_last) begin
          state_d = STOP;
          baud_d  = '0;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (baud_last) begin
          baud_d = '0;
          // Back-to-back frames: next start bit follows the stop bit with no idle gap
          if (Count != '0) begin
            pop     = 1'b1;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
    endcase
    if (pop) begin
      shift_d = head;
`ifdef UART_TX_PARITY_EN
      par_d   = ^head;
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      if (push) wr_ptr_q <= wr_ptr_q + CW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + CW'(1);
    end
  end

  // Data storage carries no reset; it is only observed after a pop loads it
  always_ff @(posedge Clk) begin
    shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
    par_q   <= par_d;
`endif
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= Data_in;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a line monitor decodes frames and checks them against a byte scoreboard.
`timescale 1ns/1ps

module tb_uart_tx_fifo;
  localparam int B     = 24;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] Data_in;
  logic       Valid;
  logic       Ready;
  logic       TX;
  logic       Busy;
  logic [2:0] Count;

  int         pass_cnt = 0;
  int         total_cnt = 0;
  logic [7:0] sb [$];
  int         frames_done = 0;
  int         idle_cnt = 0;
  int         last_gap = -1;
  bit         mon_en = 1'b0;
  logic       last_par = 1'b0;

  uart_tx_fifo #(.Baudrate(B), .DEPTH(DEPTH)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Data_in (Data_in),
    .Valid   (Valid),
    .Ready   (Ready),
    .TX      (TX),
    .Busy    (Busy),
    .Count   (Count)
  );

  always #2 Clk = ~Clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [NB-1:0] frame_of(logic [7:0] d);
    logic [NB-1:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
`ifdef UART_TX_PARITY_EN
    f[9]   = ^d;
`endif
    return f;
  endfunction

  task automatic push_byte(logic [7:0] d, logic acc);
    Data_in = d;
    Valid   = 1'b1;
    check("ready_at_push", 32'(Ready), 32'(acc));
    if (acc) sb.push_back(d);
    @(negedge Clk);
  endtask

  task automatic wait_frames(int target);
    int n = 0;
    while (frames_done < target && n < 8 * NB * B) begin
      @(negedge Clk);
      #1;
      n++;
    end
    check("frames_done", 32'(frames_done), 32'(target));
  endtask

  // Line monitor: samples every cycle of every bit of a frame
  initial begin : monitor
    logic [NB-1:0] rx;
    logic [NB-1:0] stable;
    logic [7:0]    e;
    forever begin
      @(negedge Clk);
      if (TX === 1'b1) idle_cnt++;
      else if (mon_en && TX === 1'b0) begin
        last_gap = idle_cnt;
        idle_cnt = 0;
        for (int b = 0; b < NB; b++) begin
          for (int c = 0; c < B; c++) begin
            if (b != 0 || c != 0) @(negedge Clk);
            if (c == 0) begin
              rx[b]     = TX;
              stable[b] = 1'b1;
            end else if (TX !== rx[b]) begin
              stable[b] = 1'b0;
            end
          end
        end
        check("bit_width", 32'(stable), 32'((1 << NB) - 1));
        if (sb.size() == 0) begin
          check("sb_empty", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("frame_bits", 32'(rx), 32'(frame_of(e)));
          check("rx_byte", 32'(rx[8:1]), 32'(e));
          last_par = rx[9];
        end
        frames_done++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    Reset   = 1'b1;
    Valid   = 1'b0;
    Data_in = 8'h00;
    repeat (3) @(negedge Clk);
    check("rst_tx", 32'(TX), 32'd1);
    check("rst_ready", 32'(Ready), 32'd1);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_count", 32'(Count), 32'd0);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    mon_en = 1'b1;

    // Single byte: latency, frame shape, Busy release
    push_byte(8'hA5, 1'b1);
    Valid = 1'b0;
    check("tx_before_pop", 32'(TX), 32'd1);
    check("busy_after_push", 32'(Busy), 32'd1);
    @(negedge Clk);
    check("start_latency", 32'(TX), 32'd0);
    wait_frames(1);
    check("busy_last_stop", 32'(Busy), 32'd1);
    @(negedge Clk);
    check("busy_released", 32'(Busy), 32'd0);
    check("count_empty", 32'(Count), 32'd0);
    repeat (3) @(negedge Clk);

    // Two consecutive pushes: frames must be contiguous
    push_byte(8'h55, 1'b1);
    push_byte(8'h0F, 1'b1);
    Valid = 1'b0;
    wait_frames(3);
    check("gap_0F", 32'(last_gap), 32'd0);
    repeat (3) @(negedge Clk);

    // Burst of 7: one popped, four fill the FIFO, two rejected
    for (int i = 1; i <= 7; i++) push_byte(8'(i), (i <= 5));
    Valid = 1'b0;
    check("burst_count", 32'(Count), 32'd4);
    check("burst_ready", 32'(Ready), 32'd0);
    wait_frames(8);
    check("gap_05", 32'(last_gap), 32'd0);
    repeat (3) @(negedge Clk);

    // Reset during D3 of 0xF0 aborts the frame
    mon_en  = 1'b0;
    Data_in = 8'hF0;
    Valid   = 1'b1;
    @(negedge Clk);
    Valid = 1'b0;
    @(negedge Clk);
    check("f0_start", 32'(TX), 32'd0);
    repeat (4 * B + 10) @(negedge Clk);
    check("f0_d3", 32'(TX), 32'd0);
    check("f0_busy", 32'(Busy), 32'd1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("abort_tx", 32'(TX), 32'd1);
    check("abort_count", 32'(Count), 32'd0);
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_ready", 32'(Ready), 32'd1);
    repeat (2 * B) @(negedge Clk);
    check("abort_idle", 32'(TX), 32'd1);
    mon_en = 1'b1;
    push_byte(8'h3C, 1'b1);
    Valid = 1'b0;
    wait_frames(9);

`ifdef UART_TX_PARITY_EN
    repeat (3) @(negedge Clk);
    push_byte(8'h07, 1'b1);
    Valid = 1'b0;
    wait_frames(10);
    check("parity_07", 32'(last_par), 32'd1);
    repeat (3) @(negedge Clk);
    push_byte(8'h03, 1'b1);
    Valid = 1'b0;
    wait_frames(11);
    check("parity_03", 32'(last_par), 32'd0);
`endif

    repeat (2) @(negedge Clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
